// File: rtl/fpu_issue_ctrl.sv
// FADD.S/FSUB.S issue sequencer between EX and the multi-cycle FP adder.
// Latches operands, pulses start, stalls EX, and holds the writeback until accepted.
module fpu_issue_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid_i,
  input  logic [6:0]        issue_funct7_i,
  input  logic [DATA_W-1:0] issue_rs1_i,
  input  logic [DATA_W-1:0] issue_rs2_i,
  input  logic [4:0]        issue_rd_i,
  input  logic              flush_i,
  input  logic              pipe_stall_i,
  output logic              fpu_start_o,
  output logic              fpu_sub_o,
  output logic [DATA_W-1:0] fpu_a_o,
  output logic [DATA_W-1:0] fpu_b_o,
  input  logic              fpu_done_i,
  input  logic [DATA_W-1:0] fpu_result_i,
  output logic              stall_o,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              illegal_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  op_cnt_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0000100;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              legal;
  logic              go;
  logic              bad;
  logic              done_ev;
  logic              tmo;
  logic              kill_now;
  logic              accept;
  logic              killed;
  logic [TW-1:0]     tcnt;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic              sub_q;
  logic              start_q;
  logic              illegal_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  assign legal = (issue_funct7_i == F7_ADD)
               | (issue_funct7_i == F7_SUB);

  assign go  = (state == IDLE) & issue_valid_i
             & legal & ~flush_i;
  assign bad = (state == IDLE) & issue_valid_i
             & ~legal & ~flush_i;

  // done beats timeout when both land in the same cycle
  assign done_ev = (state == BUSY) & fpu_done_i;
  assign tmo     = (state == BUSY) & ~fpu_done_i
                 & (tcnt == TW'(TIMEOUT - 1));

  assign kill_now = killed | flush_i;
  assign accept   = (state == HOLD) & ~pipe_stall_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (go) state_nxt = BUSY;
      end
      BUSY: begin
        if (done_ev) begin
          state_nxt = kill_now ? IDLE : HOLD;
        end else if (tmo) begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (!pipe_stall_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_o    = 1'b0;
    wb_valid_o = 1'b0;
    wb_rd_o    = '0;
    wb_data_o  = '0;
    unique case (state)
      IDLE: stall_o = go;
      BUSY: stall_o = 1'b1;
      HOLD: begin
        stall_o    = pipe_stall_i;
        wb_valid_o = 1'b1;
        wb_rd_o    = rd_q;
        wb_data_o  = res_q;
      end
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q   <= 1'b0;
      illegal_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      sub_q     <= 1'b0;
      res_q     <= '0;
      tcnt      <= '0;
      killed    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      start_q   <= go;
      illegal_q <= bad;
      if (go) begin
        a_q   <= issue_rs1_i;
        b_q   <= issue_rs2_i;
        rd_q  <= issue_rd_i;
        sub_q <= issue_funct7_i[2];
        tcnt  <= '0;
      end else if (state == BUSY) begin
        tcnt <= tcnt + 1'b1;
      end
      // the adder cannot abort, so a squashed op drains and is dropped
      if (state != IDLE && state_nxt == IDLE) begin
        killed <= 1'b0;
      end else if (state == BUSY && flush_i) begin
        killed <= 1'b1;
      end
      if (done_ev) res_q <= fpu_result_i;
      if (tmo) err_q <= 1'b1;
      if (accept) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign fpu_start_o = start_q;
  assign fpu_sub_o   = sub_q;
  assign fpu_a_o     = a_q;
  assign fpu_b_o     = b_q;
  assign illegal_o   = illegal_q;
  assign err_o       = err_q;
  assign op_cnt_o    = cnt_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl with a behavioural FP adder.
// Counter width is narrowed so the wrap is reachable quickly.
module tb_fpu_issue_ctrl;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid_i = 1'b0;
  logic [6:0]    issue_funct7_i = '0;
  logic [DW-1:0] issue_rs1_i = '0;
  logic [DW-1:0] issue_rs2_i = '0;
  logic [4:0]    issue_rd_i = '0;
  logic          flush_i = 1'b0;
  logic          pipe_stall_i = 1'b0;
  logic          fpu_start_o;
  logic          fpu_sub_o;
  logic [DW-1:0] fpu_a_o;
  logic [DW-1:0] fpu_b_o;
  logic          fpu_done_i = 1'b0;
  logic [DW-1:0] fpu_result_i = '0;
  logic          stall_o;
  logic          wb_valid_o;
  logic [4:0]    wb_rd_o;
  logic [DW-1:0] wb_data_o;
  logic          illegal_o;
  logic          err_o;
  logic [CW-1:0] op_cnt_o;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .DATA_W(DW),
    .TIMEOUT(15),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .issue_valid_i(issue_valid_i),
    .issue_funct7_i(issue_funct7_i),
    .issue_rs1_i(issue_rs1_i),
    .issue_rs2_i(issue_rs2_i),
    .issue_rd_i(issue_rd_i),
    .flush_i(flush_i),
    .pipe_stall_i(pipe_stall_i),
    .fpu_start_o(fpu_start_o),
    .fpu_sub_o(fpu_sub_o),
    .fpu_a_o(fpu_a_o),
    .fpu_b_o(fpu_b_o),
    .fpu_done_i(fpu_done_i),
    .fpu_result_i(fpu_result_i),
    .stall_o(stall_o),
    .wb_valid_o(wb_valid_o),
    .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o),
    .illegal_o(illegal_o),
    .err_o(err_o),
    .op_cnt_o(op_cnt_o)
  );

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } wb_t;

  wb_t           sbq[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            starts = 0;
  int            wb_total = 0;
  logic          last_sub = 1'b0;
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  int            model_lat = 3;
  bit            model_hang = 1'b0;
  logic [DW-1:0] model_res = '0;
  int            exp_cnt = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // FP adder model: done pulse in the model_lat-th cycle after start
  initial begin
    forever begin
      @(negedge clk);
      if (fpu_start_o) begin
        starts++;
        last_sub = fpu_sub_o;
        last_a = fpu_a_o;
        last_b = fpu_b_o;
        if (!model_hang) begin
          repeat (model_lat - 1) @(posedge clk);
          #1;
          fpu_done_i = 1'b1;
          fpu_result_i = model_res;
          @(posedge clk);
          #1;
          fpu_done_i = 1'b0;
        end
      end
    end
  end

  // writeback monitor
  initial begin
    forever begin
      @(negedge clk);
      if (wb_valid_o) begin
        wb_total++;
        if (sbq.size() == 0) begin
          check("wb_unexpected", 32'd1, 32'd0);
        end else begin
          check("wb_rd", 32'(wb_rd_o), 32'(sbq[0].rd));
          check("wb_data", wb_data_o, sbq[0].data);
          if (!pipe_stall_i) void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic do_op(input logic [6:0] f7,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] res,
                       input logic [4:0] rd,
                       input int hold_n,
                       input int flush_k,
                       input bit exp_wb,
                       output int n,
                       output int wbc);
    wb_t e;
    model_res = res;
    if (exp_wb) begin
      e.rd = rd;
      e.data = res;
      sbq.push_back(e);
    end
    pipe_stall_i = (hold_n > 0);
    issue_valid_i = 1'b1;
    issue_funct7_i = f7;
    issue_rs1_i = a;
    issue_rs2_i = b;
    issue_rd_i = rd;
    n = 0;
    wbc = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (wb_valid_o) wbc++;
      if (!stall_o) break;
      n++;
      @(posedge clk);
      #1;
      issue_valid_i = 1'b0;
      flush_i = (k == flush_k);
      if (wbc >= hold_n) pipe_stall_i = 1'b0;
    end
    @(posedge clk);
    #1;
    issue_valid_i = 1'b0;
    flush_i = 1'b0;
    pipe_stall_i = 1'b0;
    check("stall_bounded", 32'(n < 64), 32'd1);
  endtask

  task automatic idle_outs(input string tag);
    check({tag, "_stall"}, 32'(stall_o), 32'd0);
    check({tag, "_start"}, 32'(fpu_start_o), 32'd0);
    check({tag, "_wbv"}, 32'(wb_valid_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
    check({tag, "_cnt"}, 32'(op_cnt_o), 32'd0);
    check({tag, "_a"}, fpu_a_o, 32'd0);
  endtask

  initial begin
    int n;
    int w;
    int s0;
    int wb0;
    int k;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_outs("reset");
    check("reset_illegal", 32'(illegal_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // FADD 1.0 + 2.0
    s0 = starts;
    do_op(7'h00, 32'h3F800000, 32'h40000000, 32'h40400000,
          5'd5, 0, -1, 1'b1, n, w);
    exp_cnt++;
    check("fadd_starts", 32'(starts - s0), 32'd1);
    check("fadd_sub", 32'(last_sub), 32'd0);
    check("fadd_a", last_a, 32'h3F800000);
    check("fadd_b", last_b, 32'h40000000);
    check("fadd_stall_cyc", 32'(n), 32'd4);
    check("fadd_wb_cyc", 32'(w), 32'd1);
    check("fadd_cnt", 32'(op_cnt_o), 32'(exp_cnt));

    // FSUB 3.0 - 1.0 with 4 cycles of writeback back-pressure
    do_op(7'b0000100, 32'h40400000, 32'h3F800000, 32'h40000000,
          5'd9, 4, -1, 1'b1, n, w);
    exp_cnt++;
    check("fsub_sub", 32'(last_sub), 32'd1);
    check("fsub_stall_cyc", 32'(n), 32'd8);
    check("fsub_wb_cyc", 32'(w), 32'd5);
    check("fsub_cnt", 32'(op_cnt_o), 32'(exp_cnt));

    // flush one cycle after issue: drain, no writeback
    do_op(7'h00, 32'h11111111, 32'h22222222, 32'h33333333,
          5'd3, 0, 0, 1'b0, n, w);
    check("flush_stall_cyc", 32'(n), 32'd4);
    check("flush_wb_cyc", 32'(w), 32'd0);
    check("flush_cnt", 32'(op_cnt_o), 32'(exp_cnt));
    do_op(7'h00, 32'h44444444, 32'h55555555, 32'h66666666,
          5'd7, 0, -1, 1'b1, n, w);
    exp_cnt++;
    check("after_flush_wb_cyc", 32'(w), 32'd1);
    check("after_flush_cnt", 32'(op_cnt_o), 32'(exp_cnt));

    // unsupported funct7 and flush-wins cases
    s0 = starts;
    issue_valid_i = 1'b1;
    issue_funct7_i = 7'b0001000;
    @(negedge clk);
    check("ill_stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    issue_valid_i = 1'b0;
    @(negedge clk);
    check("ill_pulse", 32'(illegal_o), 32'd1);
    check("ill_nostart", 32'(fpu_start_o), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ill_pulse_end", 32'(illegal_o), 32'd0);
    @(posedge clk);
    #1;
    issue_valid_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk);
    check("ill_flush_stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    issue_funct7_i = 7'h00;
    @(negedge clk);
    check("ill_flush_noill", 32'(illegal_o), 32'd0);
    check("legal_flush_stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    issue_valid_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    check("legal_flush_nostart", 32'(fpu_start_o), 32'd0);
    @(posedge clk);
    #1;
    check("ill_starts", 32'(starts - s0), 32'd0);

    // timeout: adder never answers
    model_hang = 1'b1;
    do_op(7'h00, 32'h1, 32'h2, 32'h3, 5'd1, 0, -1, 1'b0, n, w);
    model_hang = 1'b0;
    check("tmo_stall_cyc", 32'(n), 32'd16);
    check("tmo_wb_cyc", 32'(w), 32'd0);
    check("tmo_err", 32'(err_o), 32'd1);
    check("tmo_cnt", 32'(op_cnt_o), 32'(exp_cnt));
    do_op(7'h00, 32'h3F800000, 32'h3F800000, 32'h40000000,
          5'd2, 0, -1, 1'b1, n, w);
    exp_cnt++;
    check("tmo_next_wb", 32'(w), 32'd1);
    check("tmo_err_sticky", 32'(err_o), 32'd1);

    // reset while BUSY, late done must be ignored
    model_lat = 6;
    model_res = 32'hDEADBEEF;
    wb0 = wb_total;
    issue_valid_i = 1'b1;
    issue_funct7_i = 7'h00;
    issue_rs1_i = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    issue_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    idle_outs("rst_busy");
    repeat (8) @(posedge clk);
    #1;
    check("rst_busy_nowb", 32'(wb_total - wb0), 32'd0);
    exp_cnt = 0;

    // reset while HOLD
    model_lat = 3;
    do_op(7'h00, 32'h7, 32'h8, 32'h9, 5'd4, 0, -1, 1'b1, n, w);
    exp_cnt++;
    model_res = 32'h12345678;
    begin
      wb_t e;
      e.rd = 5'd6;
      e.data = 32'h12345678;
      sbq.push_back(e);
    end
    pipe_stall_i = 1'b1;
    issue_valid_i = 1'b1;
    issue_rd_i = 5'd6;
    @(posedge clk);
    #1;
    issue_valid_i = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (wb_valid_o) break;
      k++;
    end
    check("hold_reached", 32'(k < 20), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    pipe_stall_i = 1'b0;
    @(negedge clk);
    idle_outs("rst_hold");
    @(posedge clk);
    #1;
    exp_cnt = 0;

    // completion counter wraps at 2^CW
    for (int i = 0; i < 16; i++) begin
      do_op(7'h00, 32'(i), 32'(i), 32'(32'h1000 + i),
            5'(i + 1), 0, -1, 1'b1, n, w);
      exp_cnt = (exp_cnt + 1) % 16;
      if (i == 14) check("cnt_max", 32'(op_cnt_o), 32'd15);
      if (i == 15) check("cnt_wrap", 32'(op_cnt_o), 32'd0);
    end
    check("sb_empty", 32'(sbq.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
